// File: rtl/inst_loop_fifo_if.sv
// Loader write port and consumer read port of the instruction loop FIFO.
// master = loader/consumer side, slave = buffer side.
interface inst_loop_fifo_if #(
    parameter int INST_LEN = 256
);
    logic                wr_valid;
    logic                wr_ready;
    logic [INST_LEN-1:0] wr_data;
    logic [INST_LEN-1:0] instruct;
    logic                inst_empty;
    logic                inst_req;

    modport master (
        output wr_valid, wr_data, inst_req,
        input  wr_ready, instruct, inst_empty
    );

    modport slave (
        input  wr_valid, wr_data, inst_req,
        output wr_ready, instruct, inst_empty
    );
endinterface

// File: rtl/inst_loop_fifo.sv
// Circular instruction buffer with show-ahead read port and a
// hardware loop mode that replays a resident block R times.
module inst_loop_fifo #(
    parameter  int INST_LEN = 256,
    parameter  int DEPTH    = 64,
    parameter  int REP_W    = 16,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_loop_fifo_if.slave    bus,
    input  logic               loop_cmd,
    input  logic [PTR_W:0]     loop_len,
    input  logic [REP_W-1:0]   loop_rep,
    output logic               loop_busy,
    output logic [REP_W-1:0]   loop_pass,
    output logic               loop_err,
    output logic [PTR_W:0]     level
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REPLAY,
        DRAIN
    } state_t;

    state_t              state;
    logic [INST_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    rd_addr;
    logic [PTR_W:0]      count;
    logic [PTR_W:0]      off;
    logic [PTR_W:0]      rem;
    logic [PTR_W:0]      len;
    logic [REP_W-1:0]    pass;
    logic [REP_W-1:0]    pass_nx;
    logic [REP_W-1:0]    rep;
    logic                push;
    logic                pop;
    logic                free;
    logic                cmd_ok;
    logic                last_off;

    assign push     = bus.wr_valid && bus.wr_ready;
    assign pop      = bus.inst_req && !bus.inst_empty;
    // Replay pops only advance the body offset; they never release entries.
    assign free     = pop && (state != REPLAY);
    assign cmd_ok   = (state == IDLE) && (loop_len != '0)
                   && (loop_len <= FULL_CNT) && (loop_rep != '0);
    assign last_off = (off == len - 1'b1);
    assign pass_nx  = pass + 1'b1;

    assign bus.wr_ready = (count != FULL_CNT);
    assign bus.instruct = mem[rd_addr];
    assign level        = count;
    assign loop_busy    = (state != IDLE);

    // Read address and empty flag: replay walks the body relative to the head.
    always_comb begin
        rd_addr        = rd_ptr;
        bus.inst_empty = (count == '0);
        if (state == REPLAY) begin
            rd_addr        = rd_ptr + off[PTR_W-1:0];
            bus.inst_empty = (off >= count);
        end
    end

    // Pass index reported to the consumer.
    always_comb begin
        loop_pass = '0;
        unique case (1'b1)
            (state == REPLAY): loop_pass = pass;
            (state == DRAIN):  loop_pass = rep - 1'b1;
            default:           loop_pass = '0;
        endcase
    end

    // Instruction storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Pointers and occupancy; a full buffer does not bypass a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (free) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !free) begin
                count <= count + 1'b1;
            end else if (!push && free) begin
                count <= count - 1'b1;
            end
        end
    end

    // Loop controller: IDLE -> REPLAY (R-1 passes) -> DRAIN (final pass).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            off      <= '0;
            pass     <= '0;
            rem      <= '0;
            len      <= '0;
            rep      <= '0;
            loop_err <= 1'b0;
        end else begin
            loop_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (loop_cmd) begin
                        if (cmd_ok) begin
                            len  <= loop_len;
                            rep  <= loop_rep;
                            off  <= '0;
                            pass <= '0;
                            rem  <= '0;
                            if (loop_rep == REP_W'(1)) begin
                                state <= DRAIN;
                                rem   <= loop_len;
                            end else begin
                                state <= REPLAY;
                            end
                        end else begin
                            loop_err <= 1'b1;
                        end
                    end
                end
                REPLAY: begin
                    if (loop_cmd) begin
                        loop_err <= 1'b1;
                    end
                    if (pop) begin
                        if (last_off) begin
                            off  <= '0;
                            pass <= pass_nx;
                            if (pass_nx == rep - 1'b1) begin
                                state <= DRAIN;
                                rem   <= len;
                            end
                        end else begin
                            off <= off + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (loop_cmd) begin
                        loop_err <= 1'b1;
                    end
                    if (pop) begin
                        rem <= rem - 1'b1;
                        if (rem == (PTR_W+1)'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/inst_loop_fifo.md
Name: inst_loop_fifo

Overview:
- Synthesizable successor to the file-backed instruction source.
- An instruction loader writes INST_LEN-bit instructions through a valid/ready port into a circular buffer.
- The datapath controller consumes them through the established show-ahead req/empty interface.
- Adds a hardware loop mode: a block of L resident instructions is replayed R times (layer/tile loops) without reloading, then freed.

Parameters:
- INST_LEN, 256: instruction width in bits.
- DEPTH, 64: buffer entries; power of two, >= 2.
- REP_W, 16: width of the repeat count.
- PTR_W, clogb2(DEPTH-1): pointer width, derived.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wr_valid  in  1  loader has an instruction.
- wr_ready  out  1  buffer accepts; equals (level < DEPTH).
- wr_data  in  INST_LEN  instruction to store.
- instruct  out  INST_LEN  current head instruction (show-ahead, combinational from memory).
- inst_empty  out  1  no instruction is presentable this cycle.
- inst_req  in  1  consumer pops the presented instruction.
- loop_cmd  in  1  single-cycle pulse to start a loop.
- loop_len  in  PTR_W+1  L, loop body length; legal range 1..DEPTH.
- loop_rep  in  REP_W  R, total passes; legal range >= 1.
- loop_busy  out  1  high in REPLAY or DRAIN.
- loop_pass  out  REP_W  index of the current pass (0-based).
- loop_err  out  1  one-cycle pulse when loop_cmd is rejected.
- level  out  PTR_W+1  count of resident entries.

Behaviour:
- Storage: mem[DEPTH], wr_ptr, rd_ptr, count. Pointers wrap modulo DEPTH.
- Push: occurs when wr_valid && wr_ready; writes mem[wr_ptr], then wr_ptr+1.
- Pop: occurs when inst_req && !inst_empty. A req while empty is ignored.
- States: IDLE, REPLAY, DRAIN.
- IDLE:
  - instruct = mem[rd_ptr].
  - inst_empty = (count == 0).
  - A pop frees the entry: rd_ptr+1, count-1.
- Loop start: loop_cmd in IDLE with a legal L and R latches L and R, and clears off, pass and rem.
  - R == 1 goes to DRAIN with rem = L.
  - Otherwise goes to REPLAY.
  - The head at the time of loop_cmd is body entry 0.
- loop_cmd rejection: rejected when not in IDLE, L == 0, L > DEPTH, or R == 0.
  - Effect: loop_err = 1 for one cycle; no state change.
- REPLAY:
  - instruct = mem[rd_ptr + off].
  - inst_empty = (off >= count), i.e. the body entry has not been loaded yet.
  - A pop does not free the entry: off+1.
  - When off == L-1, a pop sets off = 0 and pass+1.
  - If the new pass == R-1, the state goes to DRAIN with rem = L.
- DRAIN (final pass):
  - Behaves like IDLE pops: each pop frees an entry and decrements rem.
  - The pop with rem == 1 returns to IDLE.
  - inst_empty = (count == 0).
- Writes are accepted in every state whenever wr_ready is high. Entries beyond the body queue normally behind it.
- Push and pop together:
  - In IDLE/DRAIN: count is unchanged.
  - In REPLAY: count+1.
- Full: wr_ready is 0 when count == DEPTH. There is no same-cycle bypass, even if a pop occurs.
- Empty:
  - instruct is don't-care when inst_empty is high.
  - The pop is ignored; no pointer or count changes.
- Reset values (next edge with rst_n low):
  - State IDLE; pointers, count, off, pass, rem = 0.
  - loop_busy = 0, loop_err = 0, level = 0, inst_empty = 1, wr_ready = 1.
  - Buffer contents are not cleared.
  - Reset mid-loop aborts the loop and discards all entries.
- Latency:
  - A pushed entry is visible on instruct the cycle after the push edge.
  - The pop effect is visible the next cycle.
- loop_pass = pass in REPLAY, R-1 in DRAIN, 0 in IDLE.

Test Plan:
- Push 0x11..0x14 (4 entries), then pop 4 times → instruct 0x11,0x12,0x13,0x14 in order; level 4→0; inst_empty = 1 after the last pop.
- Push 64 entries with DEPTH = 64 → wr_ready = 0, level = 64. A 65th wr_valid is not accepted. One pop restores wr_ready = 1 the next cycle. Continue pushing and popping for 200 entries to verify pointer wrap-around.
- Push A,B,C,D,E; loop_cmd with L = 3, R = 3 → 9 pops give A,B,C,A,B,C,A,B,C with loop_pass 0,1,2; level stays 5 until DRAIN, ending at 2. The next pop gives D; loop_busy is 0.
- Push only A; loop_cmd with L = 2, R = 2 → pop A, then inst_empty = 1 while off = 1. Push B → B presented next cycle. Sequence A,B,A,B.
- loop_cmd with L = 0, L = 65, or R = 0, and loop_cmd during REPLAY → loop_err pulses for one cycle; state and outputs otherwise unchanged.
- Assert rst_n low during REPLAY pass 1 → next cycle level = 0, inst_empty = 1, loop_busy = 0, loop_pass = 0.
